// File: rtl/screen_scanout.sv
// screen_scanout: walks the 256x32-word Hack screen map and streams one pixel per
// handshake, bit 0 of each word first, tagged with its x/y position.
module screen_scanout (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   output logic [12:0] mem_address,
   input  logic [15:0] mem_data,
   output logic        pixel,
   output logic        pixel_valid,
   input  logic        pixel_ready,
   output logic [8:0]  x,
   output logic [7:0]  y,
   output logic        line_start,
   output logic        frame_start,
   output logic        frame_done,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;
   state_t      state_q;
   logic [15:0] sr_q;
   logic [3:0]  cnt_q;
   logic [12:0] addr_q;
   logic [8:0]  x_q;
   logic [7:0]  y_q;
   logic        done_q;
   logic        hs;
   logic        last;
   assign pixel_valid = state_q == SHIFT;
   assign hs          = pixel_valid && pixel_ready;
   assign last        = x_q == 9'd511 && y_q == 8'd255;
   assign mem_address = state_q == IDLE ? 13'd0 : addr_q;
   assign pixel       = pixel_valid & sr_q[0];
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = pixel_valid && x_q == 9'd0;
   assign frame_start = line_start && y_q == 8'd0;
   assign frame_done  = done_q;
   assign busy        = state_q != IDLE;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE:
               if (enable) begin
                  addr_q  <= '0;
                  state_q <= FETCH;
               end
            FETCH: begin
               sr_q    <= mem_data;
               cnt_q   <= '0;
               state_q <= SHIFT;
            end
            SHIFT:
               if (hs) begin
                  sr_q   <= sr_q >> 1;
                  cnt_q  <= cnt_q + 4'd1;
                  x_q    <= x_q + 9'd1;
                  done_q <= last;
                  if (x_q == 9'd511)
                     y_q <= y_q + 8'd1;
                  // enable only matters once the whole frame has gone out
                  if (cnt_q == 4'd15) begin
                     addr_q  <= addr_q + 13'd1;
                     state_q <= (last && !enable) ? IDLE : FETCH;
                  end
               end
            default: state_q <= IDLE;
         endcase
      end
endmodule
